demultiplex: RTL and testbench
==============================

Name: demultiplex

Overview:
- Inverse of the stream multiplexer. Joins one data stream with one index stream and routes each word to exactly one of N output masters, selected by the index.
- Used wherever a single producer fans out to N consumers, for example to scatter results back to the lanes they came from.
- Fully registered and able to sustain one word per cycle. A two-entry skid stage keeps the input ready signals registered.

Parameters:
- W, 8, data word width in bits (W >= 1).
- N, 2, number of output masters (N >= 2). Index width is IW = $clog2(N).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- s_stb  input  1  data slave strobe.
- s_dat  input  W  data slave word.
- s_rdy  output  1  data slave ready.
- n_stb  input  1  index slave strobe.
- n_dat  input  IW  index slave value (destination select).
- n_rdy  output  1  index slave ready.
- m_stb  output  N  output master strobes; at most one bit is set.
- m_dat  output  N*W  output master words; slice k is bits [k*W +: W].
- m_rdy  input  N  output master readies.
- err  output  1  one-cycle pulse when an out-of-range index is dropped.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values:
  - s_rdy = 0 and n_rdy = 0 during the reset cycle; both become 1 in the first cycle after rst deasserts.
  - m_stb = 0, err = 0, both buffer entries invalid.
  - m_dat is don't-care.
- Join: a transfer is accepted in a cycle only when s_stb & n_stb & s_rdy.
  - s_rdy and n_rdy are always equal. Neither side is consumed without the other.
  - A strobe on one side alone is held off and not consumed.
- Storage: main register {idx, dat, valid} drives the outputs. Skid register {idx, dat, valid} catches the word accepted while the main register is stalled.
- Ready: s_rdy = n_rdy = ~skid.valid, registered (no combinational path from m_rdy).
- Output:
  - When main.valid, m_stb = one-hot(main.idx), else m_stb = 0.
  - m_dat drives main.dat on every slice. Only the strobed slice is meaningful.
- Drain: the main entry completes when main.valid & m_rdy[main.idx]. m_rdy bits of other lanes are ignored.
- Cycle behaviour:
  - Latency is 1 cycle: a word accepted at edge t appears on m_stb/m_dat after edge t.
  - Throughput is 1 word per cycle when the selected m_rdy is held high.
  - Stall, main valid and not draining, word accepted: the word goes to skid and s_rdy drops next cycle.
  - Main draining while skid is valid: skid moves to main, skid becomes invalid, s_rdy rises next cycle.
  - Main draining (or empty) with skid empty and a word accepted: the word loads main directly.
  - Simultaneous drain and accept with skid empty: main is replaced by the new word with no bubble.
- Ordering: words leave in acceptance order across all lanes. A stall on one lane blocks all lanes (head-of-line blocking is intended).
- Out-of-range index, n_dat >= N (only possible when N is not a power of two):
  - The transfer is accepted and discarded and never enters storage.
  - err pulses high for the cycle after acceptance.
- Reset mid-operation: both entries are invalidated and in-flight words are lost. No m_stb is asserted in the cycle after the reset edge.
- Stability: main.idx and main.dat are held constant while main.valid and not drained. m_stb never drops without the matching m_rdy.

Decomposition:
- Shared stream package holds:
  - an index-width function clog2-based, minimum 1;
  - a one-hot decode function (IW to N);
  - the entry typedef {idx, dat, valid}, parameterised by W and IW.
- One natural sub-module, skid_buffer: a generic two-entry W-bit stream register with registered ready.
  - demultiplex instantiates it with payload {idx, dat}.
  - demultiplex adds the join, the index check and the one-hot output decode.

Test Plan:
- W=8,N=2: reset, then s=0xA5 with n=1, m_rdy=2'b11 -> m_stb=2'b10 and m_dat[15:8]=0xA5 one cycle after acceptance, m_stb=0 the next cycle.
- Streaming, W=8,N=4, m_rdy=4'hF: indices 0,1,2,3 with data 0x10..0x13 on consecutive cycles -> m_stb=1,2,4,8 on consecutive cycles carrying 0x10..0x13; s_rdy stays 1 throughout.
- Join hold-off: s_stb=1 with n_stb=0 for 3 cycles -> nothing accepted, m_stb=0; when n_stb rises with n=0 -> m_stb=1 the next cycle with the held word.
- Backpressure, N=2: m_rdy=0, send 0x01 to lane 0, then 0x02 to lane 1, then attempt 0x03 ->
  - 0x01 shows on m_stb[0]; 0x02 goes to skid; s_rdy=0 and 0x03 is not accepted;
  - raise m_rdy[1] only -> no progress;
  - raise m_rdy[0] -> 0x01 leaves, then 0x02 on lane 1, s_rdy=1 again.
- Out-of-range, N=3: n=3, s=0x7F accepted -> err=1 for one cycle, m_stb stays 0; next word n=2, s=0x11 -> m_stb=3'b100, data 0x11.
- Reset mid-operation: main and skid both valid, assert rst for one cycle -> m_stb=0 and s_rdy=0 that cycle; s_rdy=1 after; the old words never appear on the outputs.

Source files
------------

// File: rtl/demultiplex_pkg.sv
// rtl/demultiplex_pkg.sv - shared helpers for the stream demultiplexer
package demultiplex_pkg;

    localparam int MAX_N = 64;

    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic logic [MAX_N-1:0] onehot(input logic [31:0] idx);
        logic [MAX_N-1:0] v;
        v = '0;
        v[idx[5:0]] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/demultiplex_skid_buffer.sv
// rtl/demultiplex_skid_buffer.sv - two-entry stream register with registered ready
module skid_buffer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         s_tvalid,
    input  logic [W-1:0] s_tdata,
    output logic         s_tready,
    output logic         m_tvalid,
    output logic [W-1:0] m_tdata,
    input  logic         m_tready
);

    logic         main_valid;
    logic         skid_valid;
    logic         rdy_q;
    logic [W-1:0] main_dat;
    logic [W-1:0] skid_dat;
    logic         accept;
    logic         main_free;

    assign accept    = s_tvalid & rdy_q;
    assign main_free = ~main_valid | m_tready;

    // rdy_q always mirrors ~skid_valid, so no word arrives while skid is full
    always_ff @(posedge clk) begin
        if (rst) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            rdy_q      <= 1'b0;
        end else if (main_free) begin
            rdy_q <= 1'b1;
            if (skid_valid) begin
                main_valid <= 1'b1;
                main_dat   <= skid_dat;
                skid_valid <= 1'b0;
            end else begin
                main_valid <= accept;
                if (accept) main_dat <= s_tdata;
            end
        end else if (accept) begin
            skid_valid <= 1'b1;
            skid_dat   <= s_tdata;
            rdy_q      <= 1'b0;
        end else begin
            rdy_q <= ~skid_valid;
        end
    end

    assign s_tready = rdy_q;
    assign m_tvalid = main_valid;
    assign m_tdata  = main_dat;

endmodule

// File: rtl/demultiplex.sv
// rtl/demultiplex.sv - join data and index streams and route each word to one of N masters
module demultiplex
    import demultiplex_pkg::*;
#(
    parameter  int W  = 8,
    parameter  int N  = 2,
    localparam int IW = idx_width(N)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           s_stb,
    input  logic [W-1:0]   s_dat,
    output logic           s_rdy,
    input  logic           n_stb,
    input  logic [IW-1:0]  n_dat,
    output logic           n_rdy,
    output logic [N-1:0]   m_stb,
    output logic [N*W-1:0] m_dat,
    input  logic [N-1:0]   m_rdy,
    output logic           err
);

    typedef struct packed {
        logic [IW-1:0] idx;
        logic [W-1:0]  dat;
    } payload_t;

    payload_t         in_pl;
    payload_t         main_pl;
    logic             main_valid;
    logic             rdy;
    logic             in_range;
    logic             joined;
    logic [MAX_N-1:0] oh_full;

    generate
        if ((1 << IW) == N) begin : g_pow2
            assign in_range = 1'b1;
        end else begin : g_range
            assign in_range = ({{(32-IW){1'b0}}, n_dat} < N);
        end
    endgenerate

    assign joined = s_stb & n_stb;
    assign in_pl  = '{idx: n_dat, dat: s_dat};

    // out-of-range words are consumed here and never reach the buffer
    skid_buffer #(.W(IW + W)) u_skid (
        .clk      (clk),
        .rst      (rst),
        .s_tvalid (joined & in_range),
        .s_tdata  (in_pl),
        .s_tready (rdy),
        .m_tvalid (main_valid),
        .m_tdata  (main_pl),
        .m_tready (m_rdy[main_pl.idx])
    );

    always_ff @(posedge clk) begin
        if (rst) err <= 1'b0;
        else     err <= joined & rdy & ~in_range;
    end

    assign oh_full = onehot({{(32-IW){1'b0}}, main_pl.idx});
    assign m_stb   = main_valid ? oh_full[N-1:0] : '0;
    assign m_dat   = {N{main_pl.dat}};
    assign s_rdy   = rdy;
    assign n_rdy   = rdy;

endmodule

// File: tb/tb_demultiplex.sv
// tb/tb_demultiplex.sv - directed self-checking bench for demultiplex
module tb_demultiplex;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        s_stb2, s_rdy2, n_stb2, n_rdy2, err2;
    logic [7:0]  s_dat2;
    logic [0:0]  n_dat2;
    logic [1:0]  m_stb2, m_rdy2;
    logic [15:0] m_dat2;

    logic        s_stb4, s_rdy4, n_stb4, n_rdy4, err4;
    logic [7:0]  s_dat4;
    logic [1:0]  n_dat4;
    logic [3:0]  m_stb4, m_rdy4;
    logic [31:0] m_dat4;

    logic        s_stb3, s_rdy3, n_stb3, n_rdy3, err3;
    logic [7:0]  s_dat3;
    logic [1:0]  n_dat3;
    logic [2:0]  m_stb3, m_rdy3;
    logic [23:0] m_dat3;

    demultiplex #(.W(8), .N(2)) u2 (
        .clk(clk), .rst(rst), .s_stb(s_stb2), .s_dat(s_dat2), .s_rdy(s_rdy2),
        .n_stb(n_stb2), .n_dat(n_dat2), .n_rdy(n_rdy2),
        .m_stb(m_stb2), .m_dat(m_dat2), .m_rdy(m_rdy2), .err(err2));

    demultiplex #(.W(8), .N(4)) u4 (
        .clk(clk), .rst(rst), .s_stb(s_stb4), .s_dat(s_dat4), .s_rdy(s_rdy4),
        .n_stb(n_stb4), .n_dat(n_dat4), .n_rdy(n_rdy4),
        .m_stb(m_stb4), .m_dat(m_dat4), .m_rdy(m_rdy4), .err(err4));

    demultiplex #(.W(8), .N(3)) u3 (
        .clk(clk), .rst(rst), .s_stb(s_stb3), .s_dat(s_dat3), .s_rdy(s_rdy3),
        .n_stb(n_stb3), .n_dat(n_dat3), .n_rdy(n_rdy3),
        .m_stb(m_stb3), .m_dat(m_dat3), .m_rdy(m_rdy3), .err(err3));

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        s_stb2 = 0; n_stb2 = 0; s_dat2 = 0; n_dat2 = 0; m_rdy2 = 0;
        s_stb4 = 0; n_stb4 = 0; s_dat4 = 0; n_dat4 = 0; m_rdy4 = 0;
        s_stb3 = 0; n_stb3 = 0; s_dat3 = 0; n_dat3 = 0; m_rdy3 = 0;

        step();
        chk("reset_s_rdy", 32'(s_rdy2), 0);
        chk("reset_n_rdy", 32'(n_rdy2), 0);
        chk("reset_m_stb", 32'(m_stb2), 0);
        chk("reset_err", 32'(err2), 0);
        rst = 1'b0;
        step();
        chk("post_reset_s_rdy", 32'(s_rdy2), 1);
        chk("post_reset_n_rdy", 32'(n_rdy4), 1);

        // single word to lane 1
        m_rdy2 = 2'b11;
        s_stb2 = 1; n_stb2 = 1; s_dat2 = 8'hA5; n_dat2 = 1'b1;
        step();
        s_stb2 = 0; n_stb2 = 0;
        chk("single_m_stb", 32'(m_stb2), 32'h2);
        chk("single_m_dat", 32'(m_dat2[15:8]), 32'hA5);
        step();
        chk("single_idle", 32'(m_stb2), 0);

        // streaming across four lanes
        m_rdy4 = 4'hF;
        for (int i = 0; i < 4; i++) begin
            s_stb4 = 1; n_stb4 = 1; s_dat4 = 8'(8'h10 + i); n_dat4 = 2'(i);
            step();
            chk("stream_s_rdy", 32'(s_rdy4), 1);
            chk("stream_m_stb", 32'(m_stb4), 32'(1 << i));
            chk("stream_m_dat", 32'(m_dat4[i*8 +: 8]), 32'(8'h10 + i));
        end
        s_stb4 = 0; n_stb4 = 0;
        step();
        chk("stream_idle", 32'(m_stb4), 0);

        // join hold-off: data strobe alone is not consumed
        s_stb2 = 1; s_dat2 = 8'h3C; n_stb2 = 0;
        repeat (3) begin
            step();
            chk("holdoff_m_stb", 32'(m_stb2), 0);
        end
        n_stb2 = 1; n_dat2 = 1'b0;
        step();
        s_stb2 = 0; n_stb2 = 0;
        chk("holdoff_m_stb_joined", 32'(m_stb2), 32'h1);
        chk("holdoff_m_dat", 32'(m_dat2[7:0]), 32'h3C);
        step();
        chk("holdoff_idle", 32'(m_stb2), 0);

        // backpressure fills main then skid
        m_rdy2 = 2'b00;
        s_stb2 = 1; n_stb2 = 1; s_dat2 = 8'h01; n_dat2 = 1'b0;
        step();
        chk("bp_first_m_stb", 32'(m_stb2), 32'h1);
        chk("bp_first_m_dat", 32'(m_dat2[7:0]), 32'h01);
        chk("bp_first_s_rdy", 32'(s_rdy2), 1);
        s_dat2 = 8'h02; n_dat2 = 1'b1;
        step();
        chk("bp_skid_s_rdy", 32'(s_rdy2), 0);
        chk("bp_skid_m_stb", 32'(m_stb2), 32'h1);
        s_dat2 = 8'h03; n_dat2 = 1'b0;
        step();
        s_stb2 = 0; n_stb2 = 0;
        chk("bp_full_s_rdy", 32'(s_rdy2), 0);
        chk("bp_full_m_dat", 32'(m_dat2[7:0]), 32'h01);
        m_rdy2 = 2'b10;
        step();
        chk("bp_wrong_lane_m_stb", 32'(m_stb2), 32'h1);
        chk("bp_wrong_lane_m_dat", 32'(m_dat2[7:0]), 32'h01);
        m_rdy2 = 2'b01;
        step();
        chk("bp_drain_m_stb", 32'(m_stb2), 32'h2);
        chk("bp_drain_m_dat", 32'(m_dat2[15:8]), 32'h02);
        chk("bp_drain_s_rdy", 32'(s_rdy2), 1);
        m_rdy2 = 2'b11;
        step();
        chk("bp_done_m_stb", 32'(m_stb2), 0);

        // out-of-range index on N=3
        m_rdy3 = 3'b111;
        s_stb3 = 1; n_stb3 = 1; s_dat3 = 8'h7F; n_dat3 = 2'd3;
        step();
        s_stb3 = 0; n_stb3 = 0;
        chk("oor_err", 32'(err3), 1);
        chk("oor_m_stb", 32'(m_stb3), 0);
        step();
        chk("oor_err_clear", 32'(err3), 0);
        chk("oor_m_stb_after", 32'(m_stb3), 0);
        s_stb3 = 1; n_stb3 = 1; s_dat3 = 8'h11; n_dat3 = 2'd2;
        step();
        s_stb3 = 0; n_stb3 = 0;
        chk("oor_next_m_stb", 32'(m_stb3), 32'h4);
        chk("oor_next_m_dat", 32'(m_dat3[23:16]), 32'h11);
        chk("oor_next_err", 32'(err3), 0);

        // reset with both entries occupied
        m_rdy2 = 2'b00;
        s_stb2 = 1; n_stb2 = 1; s_dat2 = 8'hAA; n_dat2 = 1'b0;
        step();
        s_dat2 = 8'hBB; n_dat2 = 1'b1;
        step();
        s_stb2 = 0; n_stb2 = 0;
        chk("rst_mid_full", 32'(s_rdy2), 0);
        rst = 1'b1;
        step();
        chk("rst_mid_m_stb", 32'(m_stb2), 0);
        chk("rst_mid_s_rdy", 32'(s_rdy2), 0);
        rst = 1'b0;
        step();
        chk("rst_mid_s_rdy_after", 32'(s_rdy2), 1);
        chk("rst_mid_m_stb_after", 32'(m_stb2), 0);
        m_rdy2 = 2'b11;
        step();
        chk("rst_mid_no_old", 32'(m_stb2), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
